// File: rtl/branch_cond_unit_pkg.sv
// Shared definitions for the branch condition unit and the condition evaluator.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package branch_cond_unit_pkg;

    // Condition codes carried on br_cond
    localparam logic [2:0] COND_AL = 3'b000;  // always
    localparam logic [2:0] COND_Z  = 3'b001;  // zero set
    localparam logic [2:0] COND_NZ = 3'b010;  // zero clear
    localparam logic [2:0] COND_N  = 3'b011;  // negative set
    localparam logic [2:0] COND_NN = 3'b100;  // negative clear
    localparam logic [2:0] COND_C  = 3'b101;  // carry set
    localparam logic [2:0] COND_NC = 3'b110;  // carry clear
    localparam logic [2:0] COND_NV = 3'b111;  // never

    // Bit positions inside the {c, n, z} flag word
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        ACK  = 2'd2
    } bc_state_e;

endpackage

// File: rtl/branch_cond_unit_cond_eval.sv
// Purpose: decide whether a condition code is satisfied by a {c, n, z} flag word.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
module cond_eval
    import branch_cond_unit_pkg::*;
(
    input  logic [2:0] cond_i,
    input  logic [2:0] flags_i,
    output logic       taken_o
);

    // Select the flag test named by the condition code
    always_comb begin
        taken_o = 1'b0;
        case (cond_i)
            COND_AL: taken_o = 1'b1;
            COND_Z:  taken_o = flags_i[FLAG_Z];
            COND_NZ: taken_o = ~flags_i[FLAG_Z];
            COND_N:  taken_o = flags_i[FLAG_N];
            COND_NN: taken_o = ~flags_i[FLAG_N];
            COND_C:  taken_o = flags_i[FLAG_C];
            COND_NC: taken_o = ~flags_i[FLAG_C];
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_cond_unit.sv
// Purpose: owns the PC; resolves conditional branches against the latched flags.
// Latency: br_req to br_ack is 2 cycles plus up to STALL_MAX flag-update stall cycles.
// Backpressure: none upstream; requests arriving while busy are dropped and flagged on br_drop.
module branch_cond_unit
    import branch_cond_unit_pkg::*;
#(
    parameter int PC_W      = 8,
    parameter int STALL_MAX = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [2:0]      flags,
    input  logic            flag_ld,
    input  logic            pc_inc,
    input  logic            br_req,
    input  logic [2:0]      br_cond,
    input  logic [PC_W-1:0] br_target,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            br_ack,
    output logic            br_taken,
    output logic            br_drop
);

    bc_state_e       state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] tgt_q, tgt_d;
    logic [2:0]      cond_q, cond_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            ack_q, ack_d;
    logic            taken_q, taken_d;
    logic            drop_q, drop_d;
    logic            cond_met;

    cond_eval u_cond_eval (
        .cond_i  (cond_q),
        .flags_i (flags),
        .taken_o (cond_met)
    );

    // Next-state, PC update and registered output pulses
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        cond_d  = cond_q;
        cnt_d   = cnt_q;
        taken_d = taken_q;
        ack_d   = 1'b0;
        drop_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // Increment and capture can coincide; a taken branch overwrites pc later.
                if (pc_inc) begin
                    pc_d = pc_q + PC_W'(1);
                end
                if (br_req) begin
                    cond_d  = br_cond;
                    tgt_d   = br_target;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                drop_d = br_req;
                // Flags are about to change: wait, but never longer than STALL_MAX.
                if (flag_ld && (cnt_q < 4'(STALL_MAX))) begin
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    if (cond_met) begin
                        pc_d = tgt_q;
                    end
                    taken_d = cond_met;
                    cnt_d   = 4'd0;
                    ack_d   = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                drop_d  = br_req;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            tgt_q   <= '0;
            cond_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            taken_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            cond_q  <= cond_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            taken_q <= taken_d;
            drop_q  <= drop_d;
        end
    end

    assign pc       = pc_q;
    assign busy     = busy_q;
    assign br_ack   = ack_q;
    assign br_taken = taken_q;
    assign br_drop  = drop_q;

endmodule

// File: tb/tb_branch_cond_unit.sv
// Scoreboard bench for branch_cond_unit: driver pushes expected acks, monitor checks them.
module tb_branch_cond_unit;

    localparam int SM = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] flags;
    logic       flag_ld, pc_inc, br_req;
    logic [2:0] br_cond;
    logic [7:0] br_target;
    logic [7:0] pc;
    logic       busy, br_ack, br_taken, br_drop;

    typedef struct {
        logic       taken;
        logic [7:0] pc;
        int         cyc;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks   = 0;
    int         n_fail     = 0;
    int         cyc        = 0;
    int         drops_exp  = 0;
    int         drops_seen = 0;
    logic [7:0] model_pc;

    branch_cond_unit #(.PC_W(8), .STALL_MAX(SM)) dut (
        .clk       (clk),
        .reset     (reset),
        .flags     (flags),
        .flag_ld   (flag_ld),
        .pc_inc    (pc_inc),
        .br_req    (br_req),
        .br_cond   (br_cond),
        .br_target (br_target),
        .pc        (pc),
        .busy      (busy),
        .br_ack    (br_ack),
        .br_taken  (br_taken),
        .br_drop   (br_drop)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Condition table written straight from the condition-code definitions
    function automatic logic ref_taken(input logic [2:0] c, input logic [2:0] f);
        logic z, n, cy;
        z  = f[0];
        n  = f[1];
        cy = f[2];
        case (c)
            3'd0:    return 1'b1;
            3'd1:    return z;
            3'd2:    return !z;
            3'd3:    return n;
            3'd4:    return !n;
            3'd5:    return cy;
            3'd6:    return !cy;
            default: return 1'b0;
        endcase
    endfunction

    // Monitor: every ack must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!reset) begin
            if (br_drop) drops_seen++;
            if (br_ack) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("ack_taken", int'(br_taken), int'(e.taken));
                    chk("ack_pc", int'(pc), int'(e.pc));
                    chk("ack_cycle", cyc, e.cyc);
                end
            end
        end
    end

    // One branch transaction; k = cycles flag_ld is requested high, drop_at = cycle of a stray request
    task automatic branch(input logic [2:0] cond, input logic [7:0] tgt, input logic [2:0] fl0,
                          input logic [2:0] fl_new, input int k, input logic inc, input int drop_at);
        int         eff;
        logic [2:0] fl;
        logic       tk;
        exp_t       e;
        eff = (k > SM) ? SM : k;
        // flags seen in the deciding cycle: any load in an earlier stall cycle has landed
        fl = (k >= 1 && eff >= 1) ? fl_new : fl0;
        tk = ref_taken(cond, fl);
        if (inc) model_pc = model_pc + 8'd1;
        if (tk) model_pc = tgt;
        e.taken = tk;
        e.pc    = model_pc;
        e.cyc   = cyc + 2 + eff;
        exp_q.push_back(e);
        if (drop_at > 0 && drop_at <= eff + 2) drops_exp++;

        chk("busy_idle", int'(busy), 0);
        flags     = fl0;
        br_req    = 1'b1;
        br_cond   = cond;
        br_target = tgt;
        pc_inc    = inc;
        flag_ld   = 1'b0;
        for (int c = 1; c <= eff + 2; c++) begin
            @(posedge clk);
            #1;
            if (flag_ld) flags = fl_new;
            flag_ld   = (c <= k) && (c <= eff + 1);
            br_req    = (c == drop_at);
            br_cond   = 3'($urandom);
            br_target = 8'($urandom);
            pc_inc    = 1'($urandom);
            if (c == 1) chk("busy_eval", int'(busy), 1);
        end
        @(posedge clk);
        #1;
        flag_ld = 1'b0;
        br_req  = 1'b0;
        pc_inc  = 1'b0;
        chk("pc_after", int'(pc), int'(model_pc));
    endtask

    task automatic inc_run(input int n);
        for (int i = 0; i < n; i++) begin
            pc_inc = 1'b1;
            @(posedge clk);
            #1;
            model_pc = model_pc + 8'd1;
        end
        pc_inc = 1'b0;
        chk("pc_inc", int'(pc), int'(model_pc));
    endtask

    initial begin
        logic [2:0] rc, rf0, rf1;
        logic [7:0] rt;
        logic       ri;
        reset     = 1'b1;
        flags     = 3'b000;
        flag_ld   = 1'b0;
        pc_inc    = 1'b0;
        br_req    = 1'b0;
        br_cond   = 3'b000;
        br_target = 8'h00;
        model_pc  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", int'(pc), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ack", int'(br_ack), 0);
        chk("rst_taken", int'(br_taken), 0);
        chk("rst_drop", int'(br_drop), 0);
        reset = 1'b0;

        inc_run(4);                                              // pc = 4
        branch(3'b000, 8'hFF, 3'b000, 3'b000, 0, 1'b0, 0);       // pc = FF
        inc_run(1);                                              // wraps to 00
        branch(3'b001, 8'h40, 3'b001, 3'b001, 0, 1'b0, 0);       // z set: taken
        branch(3'b010, 8'h55, 3'b001, 3'b001, 0, 1'b0, 0);       // !z: not taken
        branch(3'b101, 8'h20, 3'b000, 3'b100, 2, 1'b0, 0);       // 2 stalls, c arrives
        branch(3'b101, 8'h30, 3'b000, 3'b100, 20, 1'b0, 0);      // forced after SM stalls
        branch(3'b001, 8'h77, 3'b000, 3'b000, 0, 1'b0, 1);       // second request dropped
        branch(3'b000, 8'h10, 3'b000, 3'b000, 0, 1'b0, 0);       // pc = 10
        branch(3'b111, 8'h99, 3'b111, 3'b111, 0, 1'b1, 0);       // inc + never -> 11

        // Reset in the middle of an evaluation abandons the branch silently
        br_req    = 1'b1;
        br_cond   = 3'b000;
        br_target = 8'hAB;
        @(posedge clk);
        #1;
        br_req = 1'b0;
        chk("busy_before_rst", int'(busy), 1);
        reset = 1'b1;
        #1;
        chk("midrst_pc", int'(pc), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_ack", int'(br_ack), 0);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        model_pc = 8'h00;
        repeat (4) @(posedge clk);
        #1;
        chk("pc_after_rst", int'(pc), 0);
        chk("busy_after_rst", int'(busy), 0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                inc_run(int'($urandom_range(1, 5)));
            end else begin
                rc  = 3'($urandom);
                rt  = 8'($urandom);
                rf0 = 3'($urandom);
                rf1 = 3'($urandom);
                ri  = 1'($urandom);
                branch(rc, rt, rf0, rf1, int'($urandom_range(0, 7)), ri,
                       int'($urandom_range(0, 7)));
            end
        end

        repeat (5) @(posedge clk);
        #1;
        chk("acks_outstanding", exp_q.size(), 0);
        chk("drop_count", drops_seen, drops_exp);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_cond_unit.md
Name: branch_cond_unit

Overview:
- Consumer of the flag register: reads the latched ALU status flags, evaluates conditional-branch requests from the decoder, and owns the program counter.
- Sits between the flag register (its output side) and the instruction-fetch address path.
- Sequential: 3-state FSM, PC register, flag-update hazard stall with bounded stall counter.

Parameters:
- PC_W, 8, program counter / branch target width.
- STALL_MAX, 4, max consecutive hazard-stall cycles before forced evaluation (1..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- flags  input  3  latched flags {c, n, z} from the flag register.
- flag_ld  input  1  flag register load strobe; flags change at the next edge.
- pc_inc  input  1  sequential fetch advance.
- br_req  input  1  single-cycle branch request pulse.
- br_cond  input  3  condition code, sampled with br_req.
- br_target  input  PC_W  branch target, sampled with br_req.
- pc  output  PC_W  current program counter.
- busy  output  1  branch in flight (EVAL or ACK).
- br_ack  output  1  one-cycle completion pulse.
- br_taken  output  1  result of last branch, valid with br_ack, held until next ack.
- br_drop  output  1  one-cycle pulse: br_req arrived while busy and was discarded.

Behaviour:
- Reset (async, any state, mid-branch included): pc=0, FSM=IDLE, busy=0, br_ack=0, br_taken=0, br_drop=0, stall counter=0, captured cond/target=0. In-flight branch abandoned, no ack.
- Condition codes: 000 always; 001 z; 010 !z; 011 n; 100 !n; 101 c; 110 !c; 111 never.
- IDLE: pc_inc=1 -> pc<=pc+1, modulo 2^PC_W (all-ones wraps to 0). br_req=1 -> capture br_cond/br_target, go EVAL, busy=1 next cycle. br_req and pc_inc in same cycle: increment applied and branch captured; a taken branch later overrides pc.
- EVAL: flag_ld=1 and stall count < STALL_MAX -> remain in EVAL, count+1 (flags about to change). Otherwise evaluate the condition on the current flags; taken -> pc<=target; br_taken<=result; count<=0; go ACK. Forced evaluation when count == STALL_MAX uses the flags present in that cycle.
- ACK: br_ack=1 for exactly this cycle, busy=1; go IDLE.
- Latency: request to br_ack = 2 cycles with no stall, 2+k with k stall cycles (k <= STALL_MAX). pc holds the target starting from the br_ack cycle.
- While busy: pc_inc ignored (pc frozen except for the branch load). br_req -> discarded, br_drop=1 next cycle, captured fields unchanged.
- br_req in the ACK cycle is dropped; accepted only in IDLE.
- All outputs registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package holds:
  - Condition-code constants COND_AL, COND_Z, COND_NZ, COND_N, COND_NN, COND_C, COND_NC, COND_NV.
  - Flag bit index constants FLAG_Z=0, FLAG_N=1, FLAG_C=2.
  - FSM state encoding IDLE/EVAL/ACK.
- One sub-module, cond_eval: combinational, (cond, flags) -> taken. It is reused by the future conditional-move logic. The FSM, PC, and stall counter remain in the top block.

Test Plan:
- Reset at t=0, 4x pc_inc pulses, deassert reset -> pc=4. Reset pulse mid-EVAL -> pc=0, busy=0, no br_ack.
- pc=8'hFF, pc_inc -> pc=8'h00.
- flags=3'b001, br_req with cond=001, target=8'h40 -> br_ack 2 cycles later, br_taken=1, pc=8'h40. Repeat with cond=010 -> br_taken=0, pc unchanged.
- br_req (cond=101, target=8'h20) with flag_ld held high for 2 cycles, flags becoming 3'b100 at the stall-release edge -> ack at cycle 4, taken=1, pc=8'h20.
- flag_ld held high indefinitely -> forced evaluation after 4 stalls, br_ack at cycle 6.
- Second br_req one cycle after the first -> br_drop=1, only one br_ack. br_req with pc_inc in IDLE at pc=8'h10, cond=111 -> pc=8'h11, br_taken=0.
